tiny_dnn_stream_ctrl: RTL and testbench

Parametrised batch/stream controller for the tiny_dnn accelerator. It replaces the single-buffer batch controller with a ping-pong source buffer scheme, so the next sample streams in while the cores compute the current one. It sequences the source AXI-stream fill, the per-sample compute start/finish handshake, and the destination AXI-stream drain. It sits between the DMA streams and the src/dst buffers plus the core sequencer.

---
 rtl/tiny_dnn_stream_ctrl_if.sv | 40 ++++
 rtl/tiny_dnn_stream_ctrl.sv | 153 +++++++++++++++
 tb/tb_tiny_dnn_stream_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny_dnn_stream_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tiny_dnn_stream_ctrl_if : source fill, core handshake and destination drain bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface tiny_dnn_stream_ctrl_if #(
  parameter int AW    = 12,
  parameter int NBANK = 2
);
  localparam int BW = $clog2(NBANK);

  logic          src_valid;
  logic          src_last;
  logic          src_ready;
  logic          src_v;
  logic [BW-1:0] src_wb;
  logic [AW-1:0] src_a;
  logic          s_init;
  logic [BW-1:0] s_bank;
  logic          s_fin;
  logic          dst_v;
  logic [AW-1:0] dst_a;
  logic          dst_valid;
  logic          dst_last;
  logic          dst_ready;

  // master: the controller; slave: DMA streams, buffers and core sequencer
  modport master (
    input  src_valid, src_last, s_fin, dst_ready,
    output src_ready, src_v, src_wb, src_a, s_init, s_bank,
           dst_v, dst_a, dst_valid, dst_last
  );

  modport slave (
    output src_valid, src_last, s_fin, dst_ready,
    input  src_ready, src_v, src_wb, src_a, s_init, s_bank,
           dst_v, dst_a, dst_valid, dst_last
  );
endinterface
`default_nettype wire

// File: rtl/tiny_dnn_stream_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tiny_dnn_stream_ctrl : ping-pong source fill, compute handshake, destination drain
// Revision 1.0
// ----------------------------------------------------------------------------
module tiny_dnn_stream_ctrl #(
  parameter int AW    = 12,
  parameter int NBANK = 2,
  parameter int CW    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_run,
  input  logic [AW-1:0]          i_ss,
  input  logic [AW-1:0]          i_ds,
  tiny_dnn_stream_ctrl_if.master bus,
  output logic                   o_busy,
  output logic [CW-1:0]          o_done_cnt
);
  localparam int            BW     = $clog2(NBANK);
  localparam int            FW     = $clog2(NBANK + 1);
  localparam logic [FW-1:0] C_FULL = FW'(NBANK);

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_RUN   = 2'd1,
    C_DRAIN = 2'd2
  } cstate_t;

  cstate_t       r_state;
  cstate_t       w_state_nx;
  logic          r_en;
  logic [FW-1:0] r_full_cnt;
  logic [BW-1:0] r_wb;
  logic [BW-1:0] r_rb;
  logic [AW-1:0] r_wa;
  logic [AW:0]   r_ra;
  logic [AW-1:0] r_beat_a;
  logic          r_dst_valid;
  logic [CW-1:0] r_done_cnt;

  logic w_run;
  logic w_src_ready;
  logic w_src_acc;
  logic w_src_end;
  logic w_fin;
  logic w_dst_v;
  logic w_dst_last;
  logic w_last_acc;
  logic w_s_init;

  // r_en keeps every strobe low until the first edge after reset release
  assign w_run       = i_run & r_en;
  assign w_src_ready = w_run & (r_full_cnt < C_FULL);
  assign w_src_acc   = w_src_ready & bus.src_valid;
  assign w_src_end   = w_src_acc & ((r_wa == i_ss) | bus.src_last);
  assign w_fin       = w_run & (r_state == C_RUN) & bus.s_fin;
  assign w_dst_v     = w_run & (r_state == C_DRAIN) & (r_ra <= {1'b0, i_ds})
                     & (~r_dst_valid | bus.dst_ready);
  assign w_dst_last  = r_dst_valid & (r_beat_a == i_ds);
  assign w_last_acc  = w_run & (r_state == C_DRAIN) & w_dst_last & bus.dst_ready;

  always_comb begin
    w_state_nx = r_state;
    w_s_init   = 1'b0;
    case (r_state)
      C_IDLE: begin
        if (w_run && (r_full_cnt != '0)) begin
          w_state_nx = C_RUN;
          w_s_init   = 1'b1;
        end
      end
      C_RUN: begin
        if (w_fin) w_state_nx = C_DRAIN;
      end
      C_DRAIN: begin
        if (w_last_acc) w_state_nx = C_IDLE;
      end
      default: w_state_nx = C_IDLE;
    endcase
    if (!w_run) w_state_nx = C_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= C_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_full_cnt  <= '0;
      r_wb        <= '0;
      r_rb        <= '0;
      r_wa        <= '0;
      r_ra        <= '0;
      r_beat_a    <= '0;
      r_dst_valid <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      r_en <= 1'b1;
      if (!i_run) begin
        r_full_cnt  <= '0;
        r_wb        <= '0;
        r_rb        <= '0;
        r_wa        <= '0;
        r_ra        <= '0;
        r_beat_a    <= '0;
        r_dst_valid <= 1'b0;
        r_done_cnt  <= '0;
      end else begin
        if (w_src_acc) begin
          if (w_src_end) begin
            r_wa <= '0;
            r_wb <= r_wb + BW'(1);
          end else begin
            r_wa <= r_wa + AW'(1);
          end
        end
        if (w_fin) r_rb <= r_rb + BW'(1);
        // a fill and a free in the same cycle cancel out
        r_full_cnt <= r_full_cnt + FW'(w_src_end) - FW'(w_fin);

        if (w_dst_v) begin
          r_ra     <= r_ra + (AW + 1)'(1);
          r_beat_a <= r_ra[AW-1:0];
        end else if (w_last_acc) begin
          r_ra <= '0;
        end

        if (w_dst_v)            r_dst_valid <= 1'b1;
        else if (bus.dst_ready) r_dst_valid <= 1'b0;

        if (w_last_acc) r_done_cnt <= r_done_cnt + CW'(1);
      end
    end
  end

  assign bus.src_ready = w_src_ready;
  assign bus.src_v     = w_src_acc;
  assign bus.src_wb    = r_wb;
  assign bus.src_a     = r_wa;
  assign bus.s_init    = w_s_init;
  assign bus.s_bank    = r_rb;
  assign bus.dst_v     = w_dst_v;
  assign bus.dst_a     = r_ra[AW-1:0];
  assign bus.dst_valid = r_dst_valid;
  assign bus.dst_last  = w_dst_last;

  assign o_busy     = (r_full_cnt != '0) | (r_state != C_IDLE) | r_dst_valid;
  assign o_done_cnt = r_done_cnt;
endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_stream_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tiny_dnn_stream_ctrl : vector table plus corner sequences with src/dst scoreboards
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_tiny_dnn_stream_ctrl;
  localparam int AW    = 12;
  localparam int NBANK = 2;
  localparam int CW    = 16;
  localparam int BW    = 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          run   = 1'b0;
  logic [AW-1:0] ss    = '0;
  logic [AW-1:0] ds    = '0;
  logic          busy;
  logic [CW-1:0] done_cnt;

  tiny_dnn_stream_ctrl_if #(.AW(AW), .NBANK(NBANK)) bus ();

  tiny_dnn_stream_ctrl #(.AW(AW), .NBANK(NBANK), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (run),
    .i_ss      (ss),
    .i_ds      (ds),
    .bus       (bus),
    .o_busy    (busy),
    .o_done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // destination buffer: registered read, holds when not read
  logic [3:0]  tag = '0;
  logic [15:0] dst_data = '0;
  always_ff @(posedge clk) if (bus.dst_v) dst_data <= {tag, bus.dst_a};

  int checks = 0;
  int errors = 0;
  int nwr    = 0;
  int nbeat  = 0;
  int rmode  = 0;
  int rcnt   = 0;

  logic [BW+AW-1:0] src_q[$];
  logic [16:0]      dst_q[$];

  logic [BW-1:0] m_wb   = '0;
  logic [AW-1:0] m_wa   = '0;
  logic [BW-1:0] m_rb   = '0;
  logic [CW-1:0] m_done = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // dst_ready driver: always high, or the 1,0,0,1 pattern
  initial begin
    bus.dst_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        bus.dst_ready = 1'b1;
      end else begin
        bus.dst_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        rcnt++;
      end
    end
  end

  // monitor: pops scoreboards on DUT activity, checks stall stability
  logic        hold_q    = 1'b0;
  logic        hold_last = 1'b0;
  logic [15:0] hold_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.src_v) begin
          nwr++;
          if (src_q.size() == 0) fail_evt("src_unexpected");
          else check("src_wb_a", {bus.src_wb, bus.src_a}, src_q.pop_front());
        end
        if (hold_q && run)
          check("dst_hold", {bus.dst_valid, bus.dst_last, dst_data}, {1'b1, hold_last, hold_data});
        if (bus.dst_valid && bus.dst_ready) begin
          nbeat++;
          if (dst_q.size() == 0) fail_evt("dst_unexpected");
          else check("dst_beat", {bus.dst_last, dst_data}, dst_q.pop_front());
        end
        hold_q    = run && bus.dst_valid && !bus.dst_ready;
        hold_last = bus.dst_last;
        hold_data = dst_data;
      end else begin
        hold_q = 1'b0;
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic send_beat(input logic last);
    int n = 0;
    src_q.push_back({m_wb, m_wa});
    if ((m_wa == ss) || last) begin
      m_wb++;
      m_wa = '0;
    end else begin
      m_wa++;
    end
    bus.src_valid = 1'b1;
    bus.src_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.src_ready && n < 200);
    if (!bus.src_ready) fail_evt("src_ready_timeout");
    @(posedge clk);
    #1;
    bus.src_valid = 1'b0;
    bus.src_last  = 1'b0;
  endtask

  // caller sits where outputs are settled; returns at posedge+1 in C_RUN
  task automatic wait_init(output int lat);
    lat = 0;
    while (!bus.s_init && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.s_init) begin
      fail_evt("s_init_timeout");
    end else begin
      check("s_bank", bus.s_bank, m_rb);
      @(posedge clk);
      #1;
      check("s_init_pulse", bus.s_init, 0);
    end
  endtask

  task automatic prepare_fin();
    tag++;
    for (int a = 0; a <= int'(ds); a++) dst_q.push_back({(a == int'(ds)), tag, a[AW-1:0]});
    m_rb++;
  endtask

  task automatic pulse_fin();
    prepare_fin();
    @(posedge clk);
    #1;
    bus.s_fin = 1'b1;
    @(posedge clk);
    #1;
    bus.s_fin = 1'b0;
  endtask

  // returns at the negedge where the drain has completed
  task automatic wait_drain(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!(dst_q.size() == 0 && !bus.dst_valid) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (dst_q.size() != 0 || bus.dst_valid) fail_evt("drain_timeout");
    m_done++;
    check("done_cnt", done_cnt, m_done);
  endtask

  typedef struct {
    int ss;
    int ds;
    int last_at;
    int nbeats;
    int rmode;
    int exp_wr;
    int exp_beats;
    int exp_dcyc;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cyc;
    vt[0] = '{3, 1,  3, 4, 0, 4, 2,  3};
    vt[1] = '{7, 2,  2, 3, 0, 3, 3,  4};
    vt[2] = '{2, 3, -1, 3, 1, 3, 4, -1};
    vt[3] = '{0, 0, -1, 1, 0, 1, 1,  2};
    vt[4] = '{5, 4,  5, 6, 1, 6, 5, -1};

    bus.src_valid = 1'b0;
    bus.src_last  = 1'b0;
    bus.s_fin     = 1'b0;
    run           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {busy, bus.src_ready, bus.src_v, bus.src_wb, bus.s_init, bus.s_bank,
                      bus.dst_v, bus.dst_valid, bus.dst_last, done_cnt}, 0);
    check("rst_addr", {bus.src_a, bus.dst_a}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      ss    = AW'(vt[i].ss);
      ds    = AW'(vt[i].ds);
      rmode = vt[i].rmode;
      rcnt  = 0;
      nwr   = 0;
      nbeat = 0;
      for (int b = 0; b < vt[i].nbeats; b++) send_beat(b == vt[i].last_at);
      wait_init(lat);
      check("init_lat", lat, 0);
      pulse_fin();
      wait_drain(cyc);
      if (vt[i].exp_dcyc >= 0) check("drain_cyc", cyc, vt[i].exp_dcyc);
      check("n_src_writes", nwr, vt[i].exp_wr);
      check("n_dst_beats", nbeat, vt[i].exp_beats);
      @(posedge clk);
      #1;
    end
    rmode = 0;

    // abort in the middle of a stalled drain
    ss    = AW'(1);
    ds    = AW'(3);
    rmode = 1;
    rcnt  = 0;
    send_beat(1'b0);
    send_beat(1'b1);
    wait_init(lat);
    pulse_fin();
    repeat (3) @(posedge clk);
    #1;
    run = 1'b0;
    @(negedge clk);
    check("abort_src_ready", {bus.src_ready, bus.dst_v}, 0);
    @(negedge clk);
    check("abort_idle", {bus.dst_valid, busy}, 0);
    check("abort_done_cnt", done_cnt, 0);
    dst_q.delete();
    m_wb   = '0;
    m_wa   = '0;
    m_rb   = '0;
    m_done = '0;
    rmode  = 0;
    @(posedge clk);
    #1;
    run = 1'b1;
    @(posedge clk);
    #1;

    // ping-pong: two banks fill, third sample waits for the first free
    ss = AW'(1);
    ds = AW'(1);
    fork
      begin
        for (int s = 0; s < 3; s++) begin
          send_beat(1'b0);
          send_beat(1'b0);
        end
      end
      begin
        wait_init(lat);
        repeat (6) @(negedge clk);
        check("pp_src_ready_full", bus.src_ready, 0);
        check("pp_busy", busy, 1);
        pulse_fin();
        wait_drain(cyc);
        wait_init(lat);
        pulse_fin();
        wait_drain(cyc);
        wait_init(lat);
        pulse_fin();
        wait_drain(cyc);
      end
    join
    @(posedge clk);
    #1;

    // last source beat of one bank coincides with s_fin of the other
    ss = AW'(2);
    ds = AW'(1);
    send_beat(1'b0);
    send_beat(1'b0);
    send_beat(1'b0);
    wait_init(lat);
    send_beat(1'b0);
    send_beat(1'b0);
    src_q.push_back({m_wb, m_wa});
    m_wb++;
    m_wa = '0;
    prepare_fin();
    bus.src_valid = 1'b1;
    bus.src_last  = 1'b1;
    bus.s_fin     = 1'b1;
    @(negedge clk);
    check("sim_src_ready", bus.src_ready, 1);
    @(posedge clk);
    #1;
    bus.src_valid = 1'b0;
    bus.src_last  = 1'b0;
    bus.s_fin     = 1'b0;
    check("sim_state", {bus.s_init, bus.src_ready, busy}, 3'b011);
    wait_drain(cyc);
    check("sim_drain_cyc", cyc, 3);
    wait_init(lat);
    pulse_fin();
    wait_drain(cyc);
    @(posedge clk);
    #1;

    // asynchronous reset while a source beat is being presented
    ss = AW'(3);
    send_beat(1'b0);
    src_q.push_back({m_wb, m_wa});
    bus.src_valid = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctl", {busy, bus.src_ready, bus.src_v, bus.src_wb, bus.s_init, bus.s_bank,
                       bus.dst_v, bus.dst_valid, bus.dst_last, done_cnt}, 0);
    check("arst_addr", {bus.src_a, bus.dst_a}, 0);
    bus.src_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("src_q_empty", src_q.size(), 0);
    check("dst_q_empty", dst_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
